// File: rtl/add_sub_serial_pkg.sv
// Shared types and elaboration-time helpers for the serial adder/subtractor.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package add_sub_serial_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_WAIT = 2'd2
    } state_t;

    // Number of K-bit slices needed to cover an N-bit operand.
    function automatic int num_slices(input int n, input int k);
        return n / k;
    endfunction

    // Bits needed to count 0..v-1; at least one bit so a single-slice build still has an index.
    function automatic int idx_width(input int v);
        int w;
        w = 1;
        while ((32'd1 << w) < v) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/add_sub_serial_add_k.sv
// Combinational K-bit slice adder with carry in and carry out.
// Latency: zero cycles, purely combinational.
// Backpressure: none, output follows inputs.
module add_k #(
    parameter int K = 2
) (
    input  logic [K-1:0] a,
    input  logic [K-1:0] b,
    input  logic         ci,
    output logic [K-1:0] r,
    output logic         co
);

    logic [K:0] sum;

    // Widen by one bit so the slice carry falls out of the top.
    always_comb begin
        sum = {1'b0, a} + {1'b0, b} + {{K{1'b0}}, ci};
    end

    assign r  = sum[K-1:0];
    assign co = sum[K];

endmodule

// File: rtl/add_sub_serial.sv
// Serial N-bit add/subtract, K bits per clock, LSB slice first, soc/eoc handshake.
// Latency: capture edge plus N/K slice edges; eoc rises on the first edge after that with soc low.
// Backpressure: soc is level; result and eoc are held until soc has returned low.
module add_sub_serial
    import add_sub_serial_pkg::*;
#(
    parameter int N = 8,
    parameter int K = 2
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         soc,
    input  logic [N-1:0] x,
    input  logic [N-1:0] y,
    input  logic         c_in,
    input  logic         sub,
    output logic [N-1:0] s,
    output logic         c_out,
    output logic         ow,
    output logic         eoc
);

    localparam int M  = num_slices(N, K);
    localparam int IW = idx_width(M);
    localparam logic [IW-1:0] LAST_IDX = IW'(M - 1);

    state_t        state_q, state_d;
    logic [N-1:0]  x_q, x_d;
    logic [N-1:0]  y_q, y_d;
    logic [N-1:0]  acc_q, acc_d;
    logic          carry_q, carry_d;
    logic [IW-1:0] idx_q, idx_d;
    logic          x_msb_q, x_msb_d;
    logic          y_msb_q, y_msb_d;
    logic [N-1:0]  s_q, s_d;
    logic          c_out_q, c_out_d;
    logic          ow_q, ow_d;

    logic [K-1:0]  slice_r;
    logic          slice_co;
    logic [N-1:0]  acc_next;

    // Operand registers shift right each slice, so the adder always sees bit 0 upward.
    add_k #(.K(K)) u_add_k (
        .a  (x_q[K-1:0]),
        .b  (y_q[K-1:0]),
        .ci (carry_q),
        .r  (slice_r),
        .co (slice_co)
    );

    // Result accumulator with the new slice entering at the top; after M slices it is the full word.
    always_comb begin
        acc_next = (acc_q >> K) | (N'(slice_r) << (N - K));
    end

    // Next-state and datapath: capture in IDLE, one slice per edge in CALC, wait for soc low in WAIT.
    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        acc_d   = acc_q;
        carry_d = carry_q;
        idx_d   = idx_q;
        x_msb_d = x_msb_q;
        y_msb_d = y_msb_q;
        s_d     = s_q;
        c_out_d = c_out_q;
        ow_d    = ow_q;

        case (state_q)
            S_IDLE: begin
                if (soc) begin
                    // Subtraction as x + ~y + ~borrow; carry out then means "no borrow".
                    x_d     = x;
                    y_d     = sub ? ~y : y;
                    carry_d = sub ? ~c_in : c_in;
                    x_msb_d = x[N-1];
                    y_msb_d = sub ? ~y[N-1] : y[N-1];
                    acc_d   = '0;
                    idx_d   = '0;
                    state_d = S_CALC;
                end
            end
            S_CALC: begin
                x_d     = x_q >> K;
                y_d     = y_q >> K;
                acc_d   = acc_next;
                carry_d = slice_co;
                idx_d   = idx_q + 1'b1;
                if (idx_q == LAST_IDX) begin
                    // Publish only here so partial sums never reach s.
                    s_d     = acc_next;
                    c_out_d = slice_co;
                    ow_d    = (x_msb_q == y_msb_q) && (x_msb_q != slice_r[K-1]);
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (!soc) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers; synchronous reset discards any operation in flight.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= S_IDLE;
            x_q     <= '0;
            y_q     <= '0;
            acc_q   <= '0;
            carry_q <= 1'b0;
            idx_q   <= '0;
            x_msb_q <= 1'b0;
            y_msb_q <= 1'b0;
            s_q     <= '0;
            c_out_q <= 1'b0;
            ow_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            acc_q   <= acc_d;
            carry_q <= carry_d;
            idx_q   <= idx_d;
            x_msb_q <= x_msb_d;
            y_msb_q <= y_msb_d;
            s_q     <= s_d;
            c_out_q <= c_out_d;
            ow_q    <= ow_d;
        end
    end

    assign s     = s_q;
    assign c_out = c_out_q;
    assign ow    = ow_q;
    assign eoc   = (state_q == S_IDLE);

endmodule

// File: tb/tb_add_sub_serial.sv
// Bench for add_sub_serial: three instances (K=1,2,8) share stimulus, checked against an arithmetic model.
// Latency: n/a.
// Backpressure: n/a.
module tb_add_sub_serial;

    logic       clock;
    logic       reset;
    logic       soc;
    logic [7:0] x;
    logic [7:0] y;
    logic       c_in;
    logic       sub;

    logic [7:0] s_w   [3];
    logic       c_w   [3];
    logic       ow_w  [3];
    logic       eoc_w [3];

    int KS [3] = '{1, 2, 8};
    int MS [3] = '{8, 4, 1};

    int checks   = 0;
    int failures = 0;

    add_sub_serial #(.N(8), .K(1)) dut_k1 (
        .clock(clock), .reset(reset), .soc(soc), .x(x), .y(y), .c_in(c_in), .sub(sub),
        .s(s_w[0]), .c_out(c_w[0]), .ow(ow_w[0]), .eoc(eoc_w[0])
    );
    add_sub_serial #(.N(8), .K(2)) dut_k2 (
        .clock(clock), .reset(reset), .soc(soc), .x(x), .y(y), .c_in(c_in), .sub(sub),
        .s(s_w[1]), .c_out(c_w[1]), .ow(ow_w[1]), .eoc(eoc_w[1])
    );
    add_sub_serial #(.N(8), .K(8)) dut_k8 (
        .clock(clock), .reset(reset), .soc(soc), .x(x), .y(y), .c_in(c_in), .sub(sub),
        .s(s_w[2]), .c_out(c_w[2]), .ow(ow_w[2]), .eoc(eoc_w[2])
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string name, input int j, input int act, input int exp);
        checks = checks + 1;
        if (act != exp) begin
            failures = failures + 1;
            $display("FAIL %s K=%0d t=%0t: got %0h, want %0h", name, KS[j], $time, act, exp);
        end
    endtask

    // Reference arithmetic on plain integers: returns {c_out, ow, s}.
    function automatic logic [9:0] ref_op(input logic [7:0] xv, input logic [7:0] yv,
                                          input logic ci, input logic sb);
        int ux, uy, sx, sy, u, sv;
        logic c, o;
        logic [7:0] r;
        ux = int'(xv);
        uy = int'(yv);
        sx = (ux > 127) ? ux - 256 : ux;
        sy = (uy > 127) ? uy - 256 : uy;
        if (!sb) begin
            u  = ux + uy + int'(ci);
            sv = sx + sy + int'(ci);
            c  = (u > 255);
        end else begin
            u  = ux - uy - int'(ci);
            sv = sx - sy - int'(ci);
            c  = (u >= 0);
        end
        r = u[7:0];
        o = (sv > 127) || (sv < -128);
        return {c, o, r};
    endfunction

    // Model: per instance, busy flag and edges since capture; result appears M edges after capture.
    int         busy [3];
    int         cnt  [3];
    logic [7:0] es   [3];
    logic       ec   [3];
    logic       eo   [3];
    logic [9:0] pend [3];

    initial begin
        for (int j = 0; j < 3; j++) begin
            busy[j] = 0; cnt[j] = 0; es[j] = '0; ec[j] = 1'b0; eo[j] = 1'b0; pend[j] = '0;
        end
    end

    always @(posedge clock) begin
        for (int j = 0; j < 3; j++) begin
            if (reset) begin
                busy[j] = 0; cnt[j] = 0; es[j] = '0; ec[j] = 1'b0; eo[j] = 1'b0;
            end else if (busy[j] == 0) begin
                if (soc) begin
                    busy[j] = 1;
                    cnt[j]  = 0;
                    pend[j] = ref_op(x, y, c_in, sub);
                end
            end else begin
                cnt[j] = cnt[j] + 1;
                if (cnt[j] == MS[j]) begin
                    es[j] = pend[j][7:0];
                    eo[j] = pend[j][8];
                    ec[j] = pend[j][9];
                end
                if (cnt[j] > MS[j] && !soc) busy[j] = 0;
            end
        end
    end

    // Every-cycle compare of all outputs of all instances against the model.
    always @(negedge clock) begin
        for (int j = 0; j < 3; j++) begin
            chk("mdl_eoc", j, int'(eoc_w[j]), (busy[j] == 0) ? 1 : 0);
            chk("mdl_s",   j, int'(s_w[j]),   int'(es[j]));
            chk("mdl_c",   j, int'(c_w[j]),   int'(ec[j]));
            chk("mdl_ow",  j, int'(ow_w[j]),  int'(eo[j]));
        end
    end

    // One operation with soc held h edges; checks literal results and eoc latency per instance.
    task automatic run_op(input logic [7:0] xv, input logic [7:0] yv, input logic ci,
                          input logic sb, input int h, input bit xchg,
                          input logic [7:0] xs, input logic xc, input logic xo,
                          input int l0, input int l1, input int l2);
        int  lat [3];
        int  lexp [3];
        int  e;
        bit  done;
        lat  = '{-1, -1, -1};
        lexp = '{l0, l1, l2};
        @(negedge clock);
        x = xv; y = yv; c_in = ci; sub = sb; soc = 1'b1;
        e = 0;
        done = 1'b0;
        while (!done && e <= 40) begin
            @(posedge clock);
            #1;
            if (e >= 1) begin
                for (int j = 0; j < 3; j++) begin
                    if (lat[j] < 0 && eoc_w[j]) lat[j] = e;
                end
            end
            done = (lat[0] >= 0) && (lat[1] >= 0) && (lat[2] >= 0);
            if (xchg && e == 2) x = 8'hAA;
            @(negedge clock);
            if (e == h - 1) soc = 1'b0;
            e = e + 1;
        end
        soc = 1'b0;
        chk("timeout", 0, int'(done), 1);
        for (int j = 0; j < 3; j++) begin
            chk("lat",   j, lat[j],          lexp[j]);
            chk("s",     j, int'(s_w[j]),    int'(xs));
            chk("c_out", j, int'(c_w[j]),    int'(xc));
            chk("ow",    j, int'(ow_w[j]),   int'(xo));
        end
    endtask

    initial begin
        reset = 1'b1; soc = 1'b0; x = '0; y = '0; c_in = 1'b0; sub = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        for (int j = 0; j < 3; j++) begin
            chk("rst_eoc", j, int'(eoc_w[j]), 1);
            chk("rst_s",   j, int'(s_w[j]),   0);
            chk("rst_c",   j, int'(c_w[j]),   0);
            chk("rst_ow",  j, int'(ow_w[j]),  0);
        end
        @(negedge clock);
        reset = 1'b0;
        repeat (2) @(negedge clock);

        //      x      y      ci    sub   h   xchg  s      c     ow    latency K=1,2,8
        run_op(8'h7F, 8'h01, 1'b0, 1'b0, 1,  1'b0, 8'h80, 1'b0, 1'b1, 9,  5,  2);
        run_op(8'h05, 8'h07, 1'b0, 1'b1, 1,  1'b0, 8'hFE, 1'b0, 1'b0, 9,  5,  2);
        run_op(8'h80, 8'h01, 1'b0, 1'b1, 1,  1'b0, 8'h7F, 1'b1, 1'b1, 9,  5,  2);
        run_op(8'hFF, 8'h00, 1'b1, 1'b0, 1,  1'b0, 8'h00, 1'b1, 1'b0, 9,  5,  2);
        run_op(8'h10, 8'h01, 1'b1, 1'b1, 1,  1'b0, 8'h0E, 1'b1, 1'b0, 9,  5,  2);
        run_op(8'h80, 8'h80, 1'b0, 1'b0, 1,  1'b0, 8'h00, 1'b1, 1'b1, 9,  5,  2);
        run_op(8'h12, 8'h34, 1'b0, 1'b0, 10, 1'b1, 8'h46, 1'b0, 1'b0, 10, 10, 10);

        // Reset in the middle of an add: capture, one slice edge, then reset on E0+2.
        @(negedge clock);
        x = 8'h01; y = 8'h02; c_in = 1'b0; sub = 1'b0; soc = 1'b1;
        @(negedge clock);
        soc = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
        #1;
        for (int j = 0; j < 3; j++) begin
            chk("mid_rst_eoc", j, int'(eoc_w[j]), 1);
            chk("mid_rst_s",   j, int'(s_w[j]),   0);
            chk("mid_rst_c",   j, int'(c_w[j]),   0);
            chk("mid_rst_ow",  j, int'(ow_w[j]),  0);
        end
        @(negedge clock);
        reset = 1'b0;
        run_op(8'h03, 8'h04, 1'b0, 1'b0, 1,  1'b0, 8'h07, 1'b0, 1'b0, 9,  5,  2);

        repeat (3) @(negedge clock);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/add_sub_serial.md
Name: add_sub_serial

Overview:
- Sequential, parametrised successor of the team's combinational N-bit adder.
- Adds or subtracts two N-bit operands K bits per clock, LSB slice first, through one K-bit slice adder plus a carry flip-flop.
- Produces sum/difference, carry (naturals) and overflow (integers); the user connects whichever flag fits the operand interpretation.
- Uses the team's soc/eoc start/end-of-conversion handshake, so it plugs into existing sequential networks in place of wide combinational adders.

Parameters:
- N, default 8: operand and result width; N >= 1.
- K, default 2: bits processed per cycle; 1 <= K <= N; N must be a multiple of K.
- M (localparam), N/K: number of slices.

Ports:
- clock  input  1  single system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- soc  input  1  start of conversion, level, held by the consumer.
- x  input  N  first operand, sampled only on the capture edge.
- y  input  N  second operand, sampled only on the capture edge.
- c_in  input  1  carry-in when adding; borrow-in when subtracting. Sampled on the capture edge.
- sub  input  1  0 = x+y+c_in; 1 = x-y-c_in. Sampled on the capture edge.
- s  output  N  result, registered.
- c_out  output  1  final carry; in subtract mode 1 = no borrow.
- ow  output  1  two's-complement overflow.
- eoc  output  1  end of conversion; 1 = idle and results valid.

Behaviour:
- Reset (synchronous, active-high): state IDLE, eoc=1, s=0, c_out=0, ow=0, carry FF=0, slice index=0. Reset wins over every other event, including mid-computation; a pending operation is discarded.
- States: IDLE, CALC, WAIT.
- IDLE (eoc=1):
  - On an edge with soc=1 (capture edge E0): latch x, y'=(sub ? ~y : y), and carry FF=(sub ? ~c_in : c_in).
  - Set eoc=0, index=0, go to CALC.
  - With soc=0: hold; outputs keep their last values.
- CALC (eoc=0):
  - Each edge computes slice i as {c, r} = x[iK+:K] + y'[iK+:K] + carryFF.
  - Shift r into the result shift register; carry FF <= c; index++.
  - Slice i completes at edge E0+1+i.
  - At edge E0+M (last slice), in the same edge:
    - s <= full result;
    - c_out <= final carry;
    - ow <= (x[N-1]==y'[N-1]) && (x[N-1]!=result[N-1]);
    - go to WAIT.
  - soc, x, y, sub and c_in are ignored throughout CALC.
- WAIT (eoc=0): on the first edge with soc=0, set eoc=1 and go to IDLE. Minimum latency from capture to eoc=1 is M+1 edges.
- s, c_out and ow change only at the last-slice edge or on reset. Partial results are never visible on s.
- Holding soc=1 indefinitely yields exactly one operation; a new capture needs soc to return to 0 first.
- K=N degenerates to one slice: CALC lasts one edge, latency 2.
- Arithmetic is modulo 2^N. The carry out of slice M-1 is c_out, and no further bit is kept.

Decomposition:
- Shared package holds:
  - state encoding constants S_IDLE, S_CALC, S_WAIT;
  - a constant function computing M and a log2 helper for the index width.
- One natural sub-module: add_k, the combinational K-bit slice adder.
  - Inputs a[K], b[K], ci; outputs r[K], co.
  - Instantiated once.
- Remaining RTL: FSM, operand/result shift registers, carry FF, index counter.

Test Plan:
- N=8, K=2, add 0x7F+0x01, c_in=0, soc held 1 cycle: after edge E0+4, s=0x80, c_out=0, ow=1. eoc=1 after E0+5.
- Subtract 0x05-0x07, c_in=0: s=0xFE, c_out=0 (borrow), ow=0.
- Subtract 0x80-0x01, c_in=0: s=0x7F, c_out=1, ow=1.
- Add 0xFF+0x00, c_in=1: s=0x00, c_out=1, ow=0.
- Subtract 0x10-0x01, c_in=1 (borrow-in): s=0x0E, c_out=1, ow=0.
- soc held 10 cycles; x changed to 0xAA during CALC: eoc stays 0 until one edge after soc falls. Exactly one result is produced, computed from the captured operands.
- Reset pulsed at E0+2 of an add: next edge gives eoc=1, s=0, c_out=0, ow=0. A following add 0x03+0x04 gives s=0x07 with correct latency.
- Repeat the vectors above with K=1 (latency 9) and K=8 (latency 2): identical results.
